// File: rtl/uart_time_reporter.sv
// Snapshots the stopwatch time on request and streams "HH:MM:SS.CC" (+ optional CR LF)
// to a UART transmitter one byte at a time over a start/done handshake.
module uart_time_reporter #(
    parameter bit          ADD_CRLF    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [6:0] msec,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned NBYTES = ADD_CRLF ? 13 : 11;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic [6:0]         msec_q, msec_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [15:0]        hh_asc, mm_asc, ss_asc, cc_asc;
    logic [7:0]         sel_byte;

    // Two ASCII decimal digits; anything above 99 saturates to "99".
    function automatic logic [15:0] to_ascii2(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v > 7'd99) begin
            tens = 4'd9;
            ones = 4'd9;
        end else begin
            tens = 4'(v / 7'd10);
            ones = 4'(v % 7'd10);
        end
        return {4'h3, tens, 4'h3, ones};
    endfunction

    always_comb begin
        hh_asc = to_ascii2(7'(hour_q));
        mm_asc = to_ascii2(7'(min_q));
        ss_asc = to_ascii2(7'(sec_q));
        cc_asc = to_ascii2(msec_q);
    end

    // Byte for the index about to be launched; tx_data only changes on entry to START.
    always_comb begin
        sel_byte = 8'h00;
        case (idx_d)
            4'd0:    sel_byte = hh_asc[15:8];
            4'd1:    sel_byte = hh_asc[7:0];
            4'd2:    sel_byte = 8'h3A;
            4'd3:    sel_byte = mm_asc[15:8];
            4'd4:    sel_byte = mm_asc[7:0];
            4'd5:    sel_byte = 8'h3A;
            4'd6:    sel_byte = ss_asc[15:8];
            4'd7:    sel_byte = ss_asc[7:0];
            4'd8:    sel_byte = 8'h2E;
            4'd9:    sel_byte = cc_asc[15:8];
            4'd10:   sel_byte = cc_asc[7:0];
            4'd11:   sel_byte = 8'h0D;
            4'd12:   sel_byte = 8'h0A;
            default: sel_byte = 8'h00;
        endcase
        tx_data_d = (state_d == S_START) ? sel_byte : tx_data_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        msec_d  = msec_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (send_req) begin
                    hour_d  = hour;
                    min_d   = min;
                    sec_d   = sec;
                    msec_d  = msec;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_START;
                    end
                end else if ((TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYC)) begin
                    idx_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so tx_start lines up with START.
        tx_start_d = (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            msec_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            msec_q     <= msec_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Directed bench for uart_time_reporter: one CRLF instance and one without CRLF,
// both with a short timeout, driven through a shared stimulus/observation mux.
module tb_uart_time_reporter;

    logic       clk;
    logic       rst;
    logic       sreq;
    logic       tdone;
    logic       sel;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] msec;

    logic       send_req_a, send_req_b, tx_done_a, tx_done_b;
    logic       tx_start_a, tx_start_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic       o_start, o_busy, o_done, o_err;
    logic [7:0] o_data;

    int n_vec;
    int n_err;

    logic [7:0] f1  [13];
    logic [7:0] f2  [13];
    logic [7:0] f3a [13];
    logic [7:0] f3b [13];
    logic [7:0] f6  [13];

    assign send_req_a = sreq & ~sel;
    assign send_req_b = sreq & sel;
    assign tx_done_a  = tdone & ~sel;
    assign tx_done_b  = tdone & sel;
    assign o_start    = sel ? tx_start_b : tx_start_a;
    assign o_data     = sel ? tx_data_b  : tx_data_a;
    assign o_busy     = sel ? busy_b     : busy_a;
    assign o_done     = sel ? done_b     : done_a;
    assign o_err      = sel ? err_b      : err_a;

    uart_time_reporter #(.ADD_CRLF(1'b1), .TIMEOUT_CYC(50)) u_dut_a (
        .clk(clk), .rst(rst), .send_req(send_req_a),
        .hour(hour), .min(min), .sec(sec), .msec(msec), .tx_done(tx_done_a),
        .tx_start(tx_start_a), .tx_data(tx_data_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    uart_time_reporter #(.ADD_CRLF(1'b0), .TIMEOUT_CYC(50)) u_dut_b (
        .clk(clk), .rst(rst), .send_req(send_req_b),
        .hour(hour), .min(min), .sec(sec), .msec(msec), .tx_done(tx_done_b),
        .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic request();
        sreq = 1'b1;
        tick();
        sreq = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h);
        min  = 6'(m);
        sec  = 6'(s);
        msec = 7'(c);
    endtask

    // Entered one cycle after the accepted request; tx_done answers 10 cycles after each tx_start.
    task automatic serve_frame(input logic [7:0] exp [13], input int n, input int stop_after,
                               input int req_at, input bit spur, input string tag);
        logic extra, unsteady, busy_low, early;
        extra = 0; unsteady = 0; busy_low = 0; early = 0;
        check_eq({tag, ".busy_req1"}, 32'(o_busy), 32'd1);
        check_eq({tag, ".nostart_req1"}, 32'(o_start), 32'd0);
        tick();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.start%0d", tag, i), 32'(o_start), 32'd1);
            check_eq($sformatf("%s.byte%0d", tag, i), 32'(o_data), 32'(exp[i]));
            tdone = spur;
            sreq  = (i == req_at);
            for (int j = 0; j < 10; j++) begin
                tick();
                tdone = 1'b0;
                sreq  = 1'b0;
                if (o_start) extra = 1;
                if (o_data !== exp[i]) unsteady = 1;
                if (!o_busy) busy_low = 1;
                if (o_done || o_err) early = 1;
            end
            tdone = 1'b1;
            tick();
            tdone = 1'b0;
            if (i + 1 == stop_after) break;
        end
        check_eq({tag, ".no_extra_start"}, 32'(extra), 32'd0);
        check_eq({tag, ".data_steady"}, 32'(unsteady), 32'd0);
        check_eq({tag, ".busy_held"}, 32'(busy_low), 32'd0);
        check_eq({tag, ".no_early_pulse"}, 32'(early), 32'd0);
        if (stop_after == 0) begin
            check_eq({tag, ".done"}, 32'(o_done), 32'd1);
            check_eq({tag, ".busy_at_done"}, 32'(o_busy), 32'd0);
            check_eq({tag, ".err_at_done"}, 32'(o_err), 32'd0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".done_once"}, 32'(o_done), 32'd0);
        check_eq({tag, ".idle_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, ".idle_start"}, 32'(o_start), 32'd0);
    endtask

    initial begin
        logic acc_start, acc_busy, acc_err;
        n_vec = 0;
        n_err = 0;
        f1  = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
        f2  = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h35, 8'h39, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        f3a = '{8'h30, 8'h37, 8'h3A, 8'h30, 8'h38, 8'h3A, 8'h30, 8'h39, 8'h2E, 8'h31, 8'h30, 8'h0D, 8'h0A};
        f3b = '{8'h32, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h31, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
        f6  = '{8'h30, 8'h39, 8'h3A, 8'h34, 8'h31, 8'h3A, 8'h30, 8'h37, 8'h2E, 8'h36, 8'h33, 8'h00, 8'h00};
        sel = 1'b0; rst = 1'b1; sreq = 1'b0; tdone = 1'b0;
        set_time(0, 0, 0, 0);
        tick();
        tick();
        check_eq("rst.tx_start", 32'(tx_start_a), 32'd0);
        check_eq("rst.tx_data", 32'(tx_data_a), 32'h00);
        check_eq("rst.busy", 32'(busy_a), 32'd0);
        check_eq("rst.done", 32'(done_a), 32'd0);
        check_eq("rst.err", 32'(err_a), 32'd0);
        check_eq("rst.b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        tick();

        // Basic 13-byte frame
        set_time(12, 34, 56, 78);
        request();
        serve_frame(f1, 13, 0, -1, 1'b0, "t1");
        tick();
        check_quiet("t1");

        // Snapshot must survive input changes; 120 centiseconds saturates to 99
        set_time(0, 5, 59, 120);
        sreq = 1'b1;
        tick();
        sreq = 1'b0;
        set_time(23, 59, 0, 1);
        serve_frame(f2, 13, 0, -1, 1'b0, "t2");
        tick();
        check_quiet("t2");

        // Request during byte 4 is dropped; request in the done cycle starts a new frame
        set_time(7, 8, 9, 10);
        request();
        serve_frame(f3a, 13, 0, 3, 1'b0, "t3a");
        set_time(20, 0, 1, 99);
        request();
        serve_frame(f3b, 13, 0, -1, 1'b0, "t3b");
        tick();
        check_quiet("t3b");

        // Timeout with no tx_done at all
        set_time(15, 0, 0, 0);
        request();
        check_eq("t4.busy_req1", 32'(o_busy), 32'd1);
        tick();
        check_eq("t4.start", 32'(o_start), 32'd1);
        check_eq("t4.byte0", 32'(o_data), 32'h31);
        acc_start = 0; acc_busy = 0; acc_err = 0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (o_start) acc_start = 1;
            if (!o_busy) acc_busy = 1;
            if (o_err || o_done) acc_err = 1;
        end
        check_eq("t4.no_restart", 32'(acc_start), 32'd0);
        check_eq("t4.busy_held", 32'(acc_busy), 32'd0);
        check_eq("t4.no_early_err", 32'(acc_err), 32'd0);
        tick();
        check_eq("t4.err", 32'(o_err), 32'd1);
        check_eq("t4.busy_at_err", 32'(o_busy), 32'd0);
        check_eq("t4.no_done", 32'(o_done), 32'd0);
        tick();
        check_eq("t4.err_once", 32'(o_err), 32'd0);
        check_quiet("t4");

        // Reset right after the third tx_done
        set_time(12, 34, 56, 78);
        request();
        serve_frame(f1, 13, 3, -1, 1'b0, "t5a");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5.rst_start", 32'(o_start), 32'd0);
        check_eq("t5.rst_data", 32'(o_data), 32'h00);
        check_eq("t5.rst_busy", 32'(o_busy), 32'd0);
        check_eq("t5.rst_done", 32'(o_done), 32'd0);
        check_eq("t5.rst_err", 32'(o_err), 32'd0);
        acc_start = 0; acc_busy = 0; acc_err = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (o_start) acc_start = 1;
            if (o_busy) acc_busy = 1;
            if (o_err || o_done) acc_err = 1;
        end
        check_eq("t5.no_start_after_rst", 32'(acc_start), 32'd0);
        check_eq("t5.no_busy_after_rst", 32'(acc_busy), 32'd0);
        check_eq("t5.no_pulse_after_rst", 32'(acc_err), 32'd0);
        request();
        serve_frame(f1, 13, 0, -1, 1'b0, "t5b");
        tick();
        check_quiet("t5b");

        // 11-byte frame with spurious tx_done in IDLE and coincident with every tx_start
        sel = 1'b1;
        tdone = 1'b1;
        tick();
        tick();
        tdone = 1'b0;
        check_eq("t6.spur_idle_busy", 32'(o_busy), 32'd0);
        check_eq("t6.spur_idle_start", 32'(o_start), 32'd0);
        set_time(9, 41, 7, 63);
        request();
        serve_frame(f6, 11, 0, -1, 1'b1, "t6");
        tick();
        check_quiet("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
